// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe.
//   master: operand source + result consumer (drives in_valid, A, B, S, out_ready)
//   slave : the ALU (drives in_ready, out_valid, OUT, zero, neg, ovf)
// W is the operand width; OUT is 2W bits wide.
interface alu_pipe_if #(
  parameter int unsigned W = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [3:0]     S;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] OUT;
  logic           zero;
  logic           neg;
  logic           ovf;

  modport master (
    output in_valid, A, B, S, out_ready,
    input  in_ready, out_valid, OUT, zero, neg, ovf
  );

  modport slave (
    input  in_valid, A, B, S, out_ready,
    output in_ready, out_valid, OUT, zero, neg, ovf
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked W-bit ALU with a 2W-bit registered result and flags.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - alu_pipe_if.slave: in_valid/in_ready/A/B/S on the operand side,
//            out_valid/out_ready/OUT/zero/neg/ovf on the result side.
// Non-MUL ops load the result on the accept edge; MUL (opcode 5) runs an
// iterative signed shift-add over W cycles before loading the result.
module alu_pipe #(
  parameter int unsigned W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam int unsigned RW     = 2 * W;
  localparam int unsigned CW     = $clog2(W);
  localparam logic [3:0]  OP_MUL = 4'h5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] mcand_q, mcand_d;   // sign-extended A, doubled every step
  logic [W-1:0]  mplier_q, mplier_d; // B, LSB is the bit retired this step
  logic [RW-1:0] acc_q, acc_d;

  logic [RW-1:0] out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;

  logic [RW-1:0] sext_a, sext_b, zext_a, zext_b;
  logic [RW-1:0] alu_res_c;
  logic [RW-1:0] addend_c;
  logic [RW-1:0] mul_step_c;
  logic [RW-1:0] load_val_c;
  logic          load_c;
  logic          load_ovf_c;
  logic          in_ready_c;
  logic          accept_c;

  // True when r fits in a W-bit signed value (top W+1 bits all equal).
  function automatic logic fits_w(input logic [RW-1:0] r);
    fits_w = (&r[RW-1:W-1]) | ~(|r[RW-1:W-1]);
  endfunction

  assign sext_a = {{W{bus.A[W-1]}}, bus.A};
  assign sext_b = {{W{bus.B[W-1]}}, bus.B};
  assign zext_a = {{W{1'b0}}, bus.A};
  assign zext_b = {{W{1'b0}}, bus.B};

  // Single-cycle opcodes; MUL is produced by the iterative datapath.
  always_comb begin
    alu_res_c = '0;
    case (bus.S)
      4'h0: alu_res_c = sext_a + RW'(1);
      4'h1: alu_res_c = sext_b + RW'(1);
      4'h2: alu_res_c = sext_a;
      4'h3: alu_res_c = sext_b;
      4'h4: alu_res_c = sext_a - RW'(1);
      4'h5: alu_res_c = '0;
      4'h6: alu_res_c = sext_a + sext_b;
      4'h7: alu_res_c = sext_a - sext_b;
      4'h8: alu_res_c = RW'(0) - zext_a;
      4'h9: alu_res_c = RW'(0) - zext_b;
      4'hA: alu_res_c = {{W{1'b0}}, bus.A & bus.B};
      4'hB: alu_res_c = {{W{1'b0}}, bus.A | bus.B};
      4'hC: alu_res_c = {{W{1'b0}}, bus.A ^ bus.B};
      4'hD: alu_res_c = {{W{1'b0}}, ~(bus.A ^ bus.B)};
      4'hE: alu_res_c = {{W{1'b0}}, ~(bus.A & bus.B)};
      4'hF: alu_res_c = {{W{1'b0}}, ~(bus.A | bus.B)};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c && (bus.S == OP_MUL)) state_d = ST_MUL;
      ST_MUL:  if (cnt_q == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake, multiplier step and output-register next values.
  always_comb begin
    in_ready_c  = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
    accept_c    = bus.in_valid && in_ready_c;
    addend_c    = mplier_q[0] ? mcand_q : '0;
    // The final step retires B's sign bit, whose weight is negative.
    mul_step_c  = (cnt_q == '0) ? (acc_q - addend_c) : (acc_q + addend_c);

    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    load_c      = 1'b0;
    load_val_c  = alu_res_c;
    load_ovf_c  = 1'b0;
    out_valid_d = out_valid_q && !bus.out_ready;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (bus.S == OP_MUL) begin
            cnt_d       = CW'(W - 1);
            mcand_d     = sext_a;
            mplier_d    = bus.B;
            acc_d       = '0;
            out_valid_d = 1'b0;
          end else begin
            load_c     = 1'b1;
            load_val_c = alu_res_c;
            load_ovf_c = !bus.S[3] && !fits_w(alu_res_c);
          end
        end
      end
      ST_MUL: begin
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        acc_d    = mul_step_c;
        if (cnt_q == '0) begin
          load_c     = 1'b1;
          load_val_c = mul_step_c;
          load_ovf_c = !fits_w(mul_step_c);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase

    if (load_c) out_valid_d = 1'b1;
    out_d  = load_c ? load_val_c : out_q;
    zero_d = load_c ? (load_val_c == '0) : zero_q;
    neg_d  = load_c ? load_val_c[RW-1] : neg_q;
    ovf_d  = load_c ? load_ovf_c : ovf_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.OUT       = out_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

endmodule
